// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register-bank slave: the five channels plus
// master/slave views. Clock and reset travel separately as plain ports.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    // Write data channel
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    // Write response channel
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    // Read address channel
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    // Read data channel
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave register bank. NUM_REGS word-wide registers, each either RW
// (flops driven out on reg_q) or RO (read live from reg_in). AW and W are
// accepted independently; a write commits one edge after both are held and
// raises a one-cycle wr_pulse for the target register.
module axi_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi_lite_reg_slave_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NUM_REGS_X  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic { WR_COLLECT, WR_RESP } wr_state_e;
    typedef enum logic { RD_IDLE,    RD_DATA } rd_state_e;

    // Register index carried in the address, byte offset stripped.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    // In range when no bits above the index field are set and the index exists.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] upper;
        logic [IDX_W:0]        idx_ext;
        upper   = a >> (ADDR_LSB + IDX_W);
        idx_ext = {1'b0, a[ADDR_LSB +: IDX_W]};
        return (upper == '0) && (idx_ext < NUM_REGS_X);
    endfunction

    // Byte-lane merge of new data over the old register value.
    function automatic logic [DATA_WIDTH-1:0] merge_strb(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Write channel state
    wr_state_e             wr_state_q, wr_state_d;
    logic                  aw_have_q, aw_have_d;
    logic                  w_have_q, w_have_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, wr_ok, wr_en;
    logic [IDX_W-1:0]      wr_idx;

    // Read channel state
    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_sel_data;
    logic [1:0]            rd_sel_resp;

    // Register storage and flattened views
    logic [DATA_WIDTH-1:0] regs_q   [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_in_a [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        assign reg_in_a[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign aw_hs  = s_axi.AWVALID & awready_q;
    assign w_hs   = s_axi.WVALID  & wready_q;
    assign ar_hs  = s_axi.ARVALID & arready_q;
    assign wr_idx = addr_idx(awaddr_q);
    assign rd_idx = addr_idx(s_axi.ARADDR);
    assign wr_ok  = addr_ok(awaddr_q) && !RO_MASK[wr_idx];

    // Write FSM: collect AW/W independently, commit, then hold the response.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        wr_en      = 1'b0;
        case (wr_state_q)
            WR_COLLECT: begin
                if (aw_have_q && w_have_q) begin
                    wr_state_d = WR_RESP;
                    aw_have_d  = 1'b0;
                    w_have_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    if (wr_ok) begin
                        wr_en              = 1'b1;
                        wr_pulse_d[wr_idx] = 1'b1;
                        bresp_d            = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    aw_have_d = aw_have_q | aw_hs;
                    w_have_d  = w_have_q  | w_hs;
                    awready_d = ~aw_have_d;
                    wready_d  = ~w_have_d;
                end
            end
            WR_RESP: begin
                if (s_axi.BREADY) begin
                    wr_state_d = WR_COLLECT;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = WR_COLLECT;
        endcase
    end

    // Write control state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WR_COLLECT;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Capture write address/data on their handshakes; only used once flagged.
    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_q <= s_axi.AWADDR;
        if (w_hs) begin
            wdata_q <= s_axi.WDATA;
            wstrb_q <= s_axi.WSTRB;
        end
    end

    // Register bank: byte-lane update on a committed write.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_en) begin
            regs_q[wr_idx] <= merge_strb(regs_q[wr_idx], wdata_q, wstrb_q);
        end
    end

    // Read source select: RW from flops (pre-write value), RO from fabric.
    always_comb begin
        rd_sel_data = '0;
        rd_sel_resp = RESP_SLVERR;
        if (addr_ok(s_axi.ARADDR)) begin
            rd_sel_resp = RESP_OKAY;
            rd_sel_data = RO_MASK[rd_idx] ? reg_in_a[rd_idx] : regs_q[rd_idx];
        end
    end

    // Read FSM: accept one address, register the data, hold until RREADY.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rd_state_d = RD_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_sel_data;
                    rresp_d    = rd_sel_resp;
                end
            end
            RD_DATA: begin
                if (s_axi.RREADY) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    // Protection attributes carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

endmodule
